// File: rtl/axi4_duth_noc_ni_pkg.sv
// Shared NoC NI definitions: AXI field widths, flit/header bit positions and
// the request depacketizer FSM state type.
package axi4_duth_noc_ni_pkg;

  // AxLEN(8) + AxSIZE(3) + AxBURST(2) + AxLOCK(1) + AxCACHE(4) + AxPROT(3) + AxQOS(4) + AxREGION(4)
  localparam int AXI_W_AWR_STD_FIELDS = 29;
  localparam int AXI_SPECS_WIDTH_LAST = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } req_depkt_state_t;

  // ceil(log2(n)), but never narrower than one bit
  function automatic int log2c_1if1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int flit_head_pos(input int flit_w);
    return flit_w - 1;
  endfunction

  function automatic int flit_tail_pos(input int flit_w);
    return flit_w - 2;
  endfunction

  function automatic int hdr_op_pos(input int cw_awr);
    return cw_awr;
  endfunction

  function automatic int hdr_master_pos(input int cw_awr);
    return cw_awr + 1;
  endfunction

endpackage

// File: rtl/axi_master_ni_req_depacketizer.sv
// Master NI request receive path: turns NoC request packets into AXI AW/AR
// address beats and streams write body flits out as W beats.
module axi_master_ni_req_depacketizer
  import axi4_duth_noc_ni_pkg::*;
#(
  parameter int SLAVE_ID      = 0,
  parameter int TIDS_M        = 16,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_LANES    = 4,
  parameter int USER_WIDTH    = 2,
  parameter int EXT_MASTERS   = 4,
  parameter int EXT_SLAVES    = 2,
  parameter bit HAS_WRITE     = 1'b1,
  parameter bit HAS_READ      = 1'b1,
  parameter int FLIT_WIDTH_C  = 128,
  localparam int TID_W  = log2c_1if1(TIDS_M),
  localparam int MST_W  = log2c_1if1(EXT_MASTERS),
  localparam int CW_AWR = TID_W + ADDRESS_WIDTH + USER_WIDTH + AXI_W_AWR_STD_FIELDS,
  localparam int CW_W   = TID_W + 9 * DATA_LANES + USER_WIDTH + AXI_SPECS_WIDTH_LAST
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FLIT_WIDTH_C-1:0] inp_chan,
  input  logic                    inp_valid,
  output logic                    inp_ready,
  output logic [CW_AWR-1:0]       aw_chan,
  output logic                    aw_valid,
  input  logic                    aw_ready,
  output logic [CW_W-1:0]         w_chan,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [CW_AWR-1:0]       ar_chan,
  output logic                    ar_valid,
  input  logic                    ar_ready,
  output logic                    src_push,
  output logic                    src_op,
  output logic [MST_W-1:0]        src_master,
  output logic [TID_W-1:0]        src_tid,
  input  logic                    src_ready
);

  localparam int HEAD_POS   = flit_head_pos(FLIT_WIDTH_C);
  localparam int TAIL_POS   = flit_tail_pos(FLIT_WIDTH_C);
  localparam int OP_POS     = hdr_op_pos(CW_AWR);
  localparam int MASTER_POS = hdr_master_pos(CW_AWR);

  if (FLIT_WIDTH_C < 3 + CW_AWR + MST_W || FLIT_WIDTH_C < 2 + CW_W) begin : g_bad_flit_width
    $fatal(1, "FLIT_WIDTH_C too narrow for the header or W beat");
  end
  if (SLAVE_ID >= EXT_SLAVES) begin : g_bad_slave_id
    $fatal(1, "SLAVE_ID out of range");
  end

  req_depkt_state_t  state_reg, state_next;
  logic [CW_AWR-1:0] hdr_reg, hdr_next;
  logic              op_reg, op_next;

  logic in_head, in_tail, in_op;
  assign in_head = inp_chan[HEAD_POS];
  assign in_tail = inp_chan[TAIL_POS];
  assign in_op   = inp_chan[OP_POS];

  // Header fields head straight to the source table; only the push qualifies them.
  assign src_op     = in_op;
  assign src_master = inp_chan[MASTER_POS +: MST_W];
  assign src_tid    = inp_chan[TID_W-1:0];

  assign aw_chan = hdr_reg;
  assign ar_chan = hdr_reg;
  assign w_chan  = inp_chan[CW_W-1:0];

  logic unused_flit_bits;
  assign unused_flit_bits = ^inp_chan;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      hdr_reg   <= '0;
      op_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      hdr_reg   <= hdr_next;
      op_reg    <= op_next;
    end
  end

  // Outputs are gated by rst so every valid drops in the very cycle rst is sampled.
  always_comb begin
    state_next = state_reg;
    hdr_next   = hdr_reg;
    op_next    = op_reg;
    inp_ready  = 1'b0;
    aw_valid   = 1'b0;
    ar_valid   = 1'b0;
    w_valid    = 1'b0;
    src_push   = 1'b0;
    if (!rst) begin
      case (state_reg)
        ST_IDLE: begin
          inp_ready = src_ready;
          if (inp_valid && in_head && src_ready) begin
            hdr_next   = inp_chan[CW_AWR-1:0];
            op_next    = in_op;
            src_push   = 1'b1;
            state_next = ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (op_reg) begin
            ar_valid = HAS_READ;
            if (HAS_READ && ar_ready) state_next = ST_IDLE;
          end else begin
            aw_valid = HAS_WRITE;
            if (HAS_WRITE && aw_ready) state_next = ST_DATA;
          end
        end
        ST_DATA: begin
          w_valid   = inp_valid;
          inp_ready = w_ready;
          if (inp_valid && w_ready && in_tail) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  a_idle_head_only: assert property (@(posedge clk) disable iff (rst)
    (state_reg == ST_IDLE && inp_valid && inp_ready) |-> in_head)
    else $fatal(1, "non-head flit received while idle");

  a_no_head_in_data: assert property (@(posedge clk) disable iff (rst)
    (state_reg == ST_DATA && inp_valid) |-> !in_head)
    else $fatal(1, "head flit received inside a write packet");

  a_tail_is_wlast: assert property (@(posedge clk) disable iff (rst)
    (state_reg == ST_DATA && inp_valid) |-> (in_tail == inp_chan[CW_W-1]))
    else $fatal(1, "tail flag disagrees with WLAST");

  a_write_head_not_tail: assert property (@(posedge clk) disable iff (rst)
    (state_reg == ST_IDLE && inp_valid && in_head && !in_op) |-> !in_tail)
    else $fatal(1, "write head flit carries tail");

  a_op_supported: assert property (@(posedge clk) disable iff (rst)
    src_push |-> (in_op ? HAS_READ : HAS_WRITE))
    else $fatal(1, "request op not served by this slave");

  a_aw_known: assert property (@(posedge clk) disable iff (rst)
    aw_valid |-> !$isunknown(aw_chan))
    else $fatal(1, "aw_chan unknown while valid");

  a_ar_known: assert property (@(posedge clk) disable iff (rst)
    ar_valid |-> !$isunknown(ar_chan))
    else $fatal(1, "ar_chan unknown while valid");

endmodule

// File: tb/tb_axi_master_ni_req_depacketizer.sv
// Scoreboard bench for the Master NI request depacketizer: directed packets,
// expected AXI beats queued at issue time and checked by a negedge monitor.
module tb_axi_master_ni_req_depacketizer;

  localparam int FW     = 128;
  localparam int CW_AWR = 67;
  localparam int CW_W   = 43;

  logic            clk = 1'b0;
  logic            rst;
  logic [FW-1:0]   inp_chan;
  logic            inp_valid;
  logic            inp_ready;
  logic [CW_AWR-1:0] aw_chan, ar_chan;
  logic            aw_valid, aw_ready, ar_valid, ar_ready;
  logic [CW_W-1:0] w_chan;
  logic            w_valid, w_ready;
  logic            src_push, src_op, src_ready;
  logic [1:0]      src_master;
  logic [3:0]      src_tid;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [6:0]        exp_src[$];
  logic [CW_AWR-1:0] exp_aw[$];
  logic [CW_AWR-1:0] exp_ar[$];
  logic [CW_W-1:0]   exp_w[$];

  axi_master_ni_req_depacketizer dut (
    .clk(clk), .rst(rst),
    .inp_chan(inp_chan), .inp_valid(inp_valid), .inp_ready(inp_ready),
    .aw_chan(aw_chan), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_chan(w_chan), .w_valid(w_valid), .w_ready(w_ready),
    .ar_chan(ar_chan), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .src_push(src_push), .src_op(src_op), .src_master(src_master),
    .src_tid(src_tid), .src_ready(src_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [CW_AWR-1:0] mk_awr(input logic [3:0] tid, input logic [31:0] addr,
                                               input logic [1:0] user, input logic [28:0] std);
    return {std, user, addr, tid};
  endfunction

  function automatic logic [FW-1:0] mk_head(input logic op, input logic [1:0] mst,
                                            input logic [CW_AWR-1:0] a);
    logic [FW-1:0] f;
    f = '0;
    f[FW-1] = 1'b1;
    f[FW-2] = op;
    f[CW_AWR-1:0] = a;
    f[CW_AWR] = op;
    f[CW_AWR+1 +: 2] = mst;
    return f;
  endfunction

  function automatic logic [CW_W-1:0] mk_beat(input logic last, input logic [3:0] tid,
                                              input logic [31:0] data);
    return {last, 2'b10, 4'hF, data, tid};
  endfunction

  function automatic logic [FW-1:0] mk_body(input logic [CW_W-1:0] b);
    logic [FW-1:0] f;
    f = '0;
    f[FW-2] = b[CW_W-1];
    f[CW_W-1:0] = b;
    return f;
  endfunction

  // Present one flit until accepted; returns the cycle index of the accepting edge.
  task automatic send_flit(input logic [FW-1:0] f, output int acc_cyc);
    int  waited;
    bit  done;
    waited = 0;
    done = 0;
    acc_cyc = -1;
    inp_chan = f;
    inp_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (inp_ready) begin
        acc_cyc = cyc;
        done = 1;
      end else if (++waited > 60) begin
        chk("flit_accept_timeout", 0, 1);
        done = 1;
      end
    end
    @(posedge clk);
    #1;
    inp_valid = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] mst, input logic [3:0] tid, input logic [31:0] addr);
    logic [CW_AWR-1:0] a;
    int c;
    a = mk_awr(tid, addr, 2'b00, 29'd0);
    exp_src.push_back({1'b1, mst, tid});
    exp_ar.push_back(a);
    send_flit(mk_head(1'b1, mst, a), c);
  endtask

  task automatic do_write(input logic [1:0] mst, input logic [3:0] tid, input logic [31:0] addr,
                          input int nbeats, input logic [31:0] dbase);
    logic [CW_AWR-1:0] a;
    logic [CW_W-1:0]   b;
    int c;
    a = mk_awr(tid, addr, 2'b01, 29'(nbeats - 1));
    exp_src.push_back({1'b0, mst, tid});
    exp_aw.push_back(a);
    send_flit(mk_head(1'b0, mst, a), c);
    for (int k = 0; k < nbeats; k++) begin
      b = mk_beat(k == nbeats - 1, tid, dbase + 32'(k));
      exp_w.push_back(b);
      send_flit(mk_body(b), c);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks AW stability while stalled.
  initial begin
    logic [6:0]        e_src;
    logic [CW_AWR-1:0] e_a, aw_prev;
    logic [CW_W-1:0]   e_w;
    bit aw_hold;
    aw_hold = 0;
    aw_prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_hold = 0;
      end else begin
        if (src_push) begin
          if (exp_src.size() == 0) chk("src_push_unexpected", 1, 0);
          else begin
            e_src = exp_src.pop_front();
            $display("[%0d] src push op=%0d master=%0d tid=%0d", cyc, src_op, src_master, src_tid);
            chk("src_fields", {src_op, src_master, src_tid}, e_src);
          end
        end
        if (aw_valid && aw_ready) begin
          if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
          else begin
            e_a = exp_aw.pop_front();
            $display("[%0d] AW chan=%h", cyc, aw_chan);
            chk("aw_chan", aw_chan, e_a);
            chk("aw_no_overlap_ar", ar_valid, 0);
          end
        end
        if (ar_valid && ar_ready) begin
          if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
          else begin
            e_a = exp_ar.pop_front();
            $display("[%0d] AR chan=%h", cyc, ar_chan);
            chk("ar_chan", ar_chan, e_a);
            chk("ar_no_overlap_aw", aw_valid, 0);
          end
        end
        if (w_valid && w_ready) begin
          if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
          else begin
            e_w = exp_w.pop_front();
            $display("[%0d] W beat=%h last=%0d", cyc, w_chan, w_chan[CW_W-1]);
            chk("w_chan", w_chan, e_w);
          end
        end
        if (aw_hold) chk("aw_held_stable", {aw_valid, aw_chan}, {1'b1, aw_prev});
        aw_hold = aw_valid && !aw_ready;
        aw_prev = aw_chan;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [CW_AWR-1:0] a;
    logic [CW_W-1:0]   b;
    int hc, c;

    rst = 1'b1;
    src_ready = 1'b1;
    aw_ready = 1'b1;
    ar_ready = 1'b1;
    w_ready = 1'b1;
    inp_valid = 1'b1;
    inp_chan = mk_head(1'b1, 2'd1, mk_awr(4'd1, 32'h10, 2'd0, 29'd0));

    // Reset state: a pending head must not be taken while rst is high
    repeat (2) @(negedge clk);
    chk("rst_inp_ready", inp_ready, 0);
    chk("rst_valids", {aw_valid, ar_valid, w_valid, src_push}, 4'b0000);
    @(posedge clk); #1;
    inp_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_inp_ready", inp_ready, 1);

    // Read: op=1 master=2 tid=5 addr=0x1000
    @(posedge clk); #1;
    do_read(2'd2, 4'd5, 32'h1000);
    @(negedge clk);
    chk("read_ar_valid_n1", ar_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("read_back_idle", {inp_ready, ar_valid}, 2'b10);
    @(posedge clk); #1;

    // Write 4 beats, w_ready high: AW at N+1, beats accepted at N+2..N+5
    a = mk_awr(4'd3, 32'h2000_0040, 2'b01, 29'd3);
    exp_src.push_back({1'b0, 2'd1, 4'd3});
    exp_aw.push_back(a);
    send_flit(mk_head(1'b0, 2'd1, a), hc);
    @(negedge clk);
    chk("write_aw_valid_n1", {aw_valid, inp_ready}, 2'b10);
    for (int k = 0; k < 4; k++) begin
      b = mk_beat(k == 3, 4'd3, 32'hDEAD_0000 + 32'(k));
      exp_w.push_back(b);
      send_flit(mk_body(b), c);
      chk("write_beat_cycle", c, hc + 2 + k);
    end
    repeat (2) @(posedge clk); #1;

    // Backpressure: AW stalled 3 cycles, then toggling w_ready
    aw_ready = 1'b0;
    w_ready = 1'b0;
    fork
      do_write(2'd3, 4'd7, 32'h3000, 4, 32'h0000_1000);
      begin
        int n;
        n = 0;
        while (!aw_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp_aw_seen", aw_valid, 1);
        repeat (3) @(posedge clk);
        #1 aw_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
          @(posedge clk); #1;
          w_ready = ~w_ready;
        end
        w_ready = 1'b1;
      end
    join
    chk("bp_w_all_beats", exp_w.size(), 0);
    repeat (2) @(posedge clk); #1;

    // src_ready low with head pending: no acceptance, no push
    src_ready = 1'b0;
    a = mk_awr(4'hF, 32'hFFFF_FFFC, 2'b00, 29'd0);
    inp_chan = mk_head(1'b1, 2'd0, a);
    inp_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("srcstall_inp_ready", inp_ready, 0);
      chk("srcstall_no_push", src_push, 0);
      @(posedge clk); #1;
    end
    exp_src.push_back({1'b1, 2'd0, 4'hF});
    exp_ar.push_back(a);
    src_ready = 1'b1;
    @(negedge clk);
    chk("srcstall_release", {inp_ready, src_push}, 2'b11);
    @(posedge clk); #1;
    inp_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset mid-write after beat 2
    a = mk_awr(4'd9, 32'h4000, 2'b01, 29'd3);
    exp_src.push_back({1'b0, 2'd2, 4'd9});
    exp_aw.push_back(a);
    send_flit(mk_head(1'b0, 2'd2, a), c);
    for (int k = 0; k < 2; k++) begin
      b = mk_beat(1'b0, 4'd9, 32'h0000_4400 + 32'(k));
      exp_w.push_back(b);
      send_flit(mk_body(b), c);
    end
    inp_chan = mk_body(mk_beat(1'b0, 4'd9, 32'h0000_4402));
    inp_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valids", {aw_valid, ar_valid, w_valid, src_push, inp_ready}, 5'b00000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_valids_2", {aw_valid, ar_valid, w_valid, src_push, inp_ready}, 5'b00000);
    @(posedge clk); #1;
    rst = 1'b0;
    inp_valid = 1'b0;
    do_read(2'd1, 4'd1, 32'h5000);
    repeat (3) @(posedge clk); #1;

    // Back-to-back read, write (1 beat), read
    do_read(2'd0, 4'd2, 32'h0000_0100);
    do_write(2'd1, 4'd4, 32'h0000_0200, 1, 32'hCAFE_0000);
    do_read(2'd3, 4'd6, 32'h0000_0300);
    repeat (4) @(posedge clk); #1;

    chk("end_src_queue_empty", exp_src.size(), 0);
    chk("end_aw_queue_empty", exp_aw.size(), 0);
    chk("end_ar_queue_empty", exp_ar.size(), 0);
    chk("end_w_queue_empty", exp_w.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
